victim_select: RTL
==================

VICTIM_SELECT -- requirements
Module: victim_select

Interface
REQ-001 Parameter NUM_WAYS, 4, cache associativity; power of two, >= 2.
REQ-002 Parameter NUM_SETS, 16, number of sets; power of two, >= 2.
REQ-003 clock  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 access_valid  input  1  cache hit this cycle; updates MRU.
REQ-006 access_set  input  $clog2(NUM_SETS)  hit set index.
REQ-007 access_way  input  $clog2(NUM_WAYS)  hit way index.
REQ-008 victim_req  input  1  miss needs a victim way.
REQ-009 victim_set  input  $clog2(NUM_SETS)  miss set index.
REQ-010 victim_busy  output  1  high when a request cannot be accepted.
REQ-011 victim_valid  output  1  victim result available.
REQ-012 victim_way  output  $clog2(NUM_WAYS)  selected way.
REQ-013 victim_evict  output  1  selected way currently holds a valid line.
REQ-014 victim_ack  input  1  consumer accepts the result.
REQ-015 fill_valid, fill_set, fill_way  input  1 / set / way  line installed; sets valid bit and MRU.
REQ-016 inval_valid, inval_set, inval_way  input  1 / set / way  clears the valid bit.

Function
REQ-017 FSM states: IDLE and RESP; victim_busy = (state != IDLE).
REQ-018 In IDLE, victim_req is accepted at the clock edge; the result is registered and the state moves to RESP, so victim_valid rises exactly 1 cycle after the request.
REQ-019 In RESP, victim_valid, victim_way and victim_evict are held stable until victim_ack=1; the state then returns to IDLE, and the next request is accepted no earlier than the following cycle.
REQ-020 victim_req is ignored while in RESP.
REQ-021 Selection priority: the lowest-indexed invalid way of victim_set is chosen with victim_evict=0; otherwise an NMRU way is chosen with victim_evict=1.
REQ-022 NMRU when NUM_WAYS==2: victim = ~MRU[set].
REQ-023 NMRU when NUM_WAYS>2: victim = MRU[set] + offset, computed modulo NUM_WAYS (natural wrap of the $clog2(NUM_WAYS)-bit sum).
REQ-024 offset is the output of a $clog2(NUM_WAYS)-bit maximal-length LFSR; it is never zero, so the victim never equals the MRU way.
REQ-025 The LFSR advances only on an accepted request that takes the NMRU path.
REQ-026 access_valid sets MRU[access_set] = access_way; the set's valid bits are unchanged.
REQ-027 fill_valid sets valid[fill_set][fill_way]=1 and MRU[fill_set]=fill_way.
REQ-028 inval_valid clears valid[inval_set][inval_way]; MRU is unchanged.
REQ-029 Same cycle, same set, access and fill: the fill's way wins for MRU.
REQ-030 Same cycle, same set and way, inval and fill: fill wins, so the valid bit ends at 1.
REQ-031 Selection on acceptance uses the pre-edge state; fill, inval or access in the same cycle do not affect that result.
REQ-032 Fill, inval or access to the pending set while in RESP do not alter the held result.

Reset
REQ-033 On reset: all valid bits 0, all MRU entries 0, state IDLE, victim_valid 0, victim_way 0, victim_evict 0, victim_busy 0, LFSR state 1.
REQ-034 Reset in RESP drops victim_valid on the next cycle and discards the pending result without an ack.
REQ-035 Reset has priority over every other input.

Structure
REQ-036 The shared package holds CACHE_WAY_IDX, CACHE_SET_IDX and the FSM state enum.
REQ-037 The existing LFSR module is instantiated with NUM_BITS=$clog2(NUM_WAYS) inside a generate block, only when NUM_WAYS>2.
REQ-038 Valid and MRU arrays are flip-flops local to this block; there is no SRAM macro.

Verification
REQ-039 Empty cache, req set 5 -> next cycle victim_valid=1, way 0, evict 0; after fill way 0 and a second req -> way 1, evict 0.
REQ-040 Fill ways 0-3 of set 3, access way 2, issue 12 acked reqs -> victim never 2; evict=1; ways 0, 1 and 3 each appear within every 3 consecutive results.
REQ-041 Hold victim_ack=0 for 5 cycles with fill/access traffic to the pending set -> outputs stable, victim_req ignored, victim_busy=1.
REQ-042 Fill and inval of set 7 way 1 in the same cycle -> valid=1, so the next req on full set 7 returns evict=1.
REQ-043 Full set, inval way 2, req -> way 2, evict 0; LFSR state unchanged.
REQ-044 Reset asserted in RESP -> victim_valid=0 next cycle; all sets report way 0, evict 0.

Source files
------------

// File: rtl/victim_select_pkg.sv
// Shared definitions for the victim-selection slice: default cache geometry,
// FSM state encoding and the LFSR feedback tap table.
package victim_select_pkg;

    // Index widths of the default cache geometry (4 ways, 16 sets).
    localparam int CACHE_WAY_IDX = 2;
    localparam int CACHE_SET_IDX = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } vs_state_e;

    // Feedback taps for a maximal-length shift-left Fibonacci LFSR.
    // Bit k-1 of the mask corresponds to tap k of the primitive polynomial.
    function automatic logic [31:0] lfsr_taps(input int n);
        logic [31:0] m;
        case (n)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            default: m = 32'h0000_0003;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/victim_select_lfsr.sv
// Maximal-length Fibonacci LFSR; never reaches the all-zero state, so its
// output is usable as a non-zero offset. Steps only when i_advance is high.
module victim_select_lfsr
    import victim_select_pkg::*;
#(
    parameter int NUM_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_advance,
    output logic [NUM_BITS-1:0] o_state
);

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(lfsr_taps(NUM_BITS));

    logic [NUM_BITS-1:0] r_state;
    logic                w_fb;

    assign w_fb    = ^(r_state & TAPS);
    assign o_state = r_state;

    // Seed to 1 on reset, shift in the feedback bit on each advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= NUM_BITS'(1);
        end else if (i_advance) begin
            r_state <= {r_state[NUM_BITS-2:0], w_fb};
        end
    end

endmodule

// File: rtl/victim_select.sv
// Cache victim-way selector: prefers the lowest invalid way of the miss set,
// otherwise picks a not-most-recently-used way using an LFSR offset from MRU.
// Valid bits and MRU pointers are local flops updated by hit/fill/inval.
module victim_select
    import victim_select_pkg::*;
#(
    parameter int NUM_WAYS = 1 << CACHE_WAY_IDX,
    parameter int NUM_SETS = 1 << CACHE_SET_IDX
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_access_valid,
    input  logic [$clog2(NUM_SETS)-1:0] i_access_set,
    input  logic [$clog2(NUM_WAYS)-1:0] i_access_way,
    input  logic                        i_victim_req,
    input  logic [$clog2(NUM_SETS)-1:0] i_victim_set,
    output logic                        o_victim_busy,
    output logic                        o_victim_valid,
    output logic [$clog2(NUM_WAYS)-1:0] o_victim_way,
    output logic                        o_victim_evict,
    input  logic                        i_victim_ack,
    input  logic                        i_fill_valid,
    input  logic [$clog2(NUM_SETS)-1:0] i_fill_set,
    input  logic [$clog2(NUM_WAYS)-1:0] i_fill_way,
    input  logic                        i_inval_valid,
    input  logic [$clog2(NUM_SETS)-1:0] i_inval_set,
    input  logic [$clog2(NUM_WAYS)-1:0] i_inval_way
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] r_valid;
    logic [NUM_SETS-1:0][WAY_W-1:0]    r_mru;

    vs_state_e          r_state;
    vs_state_e          w_state_nxt;
    logic               w_accept;
    logic [WAY_W-1:0]   r_way;
    logic               r_evict;

    logic [NUM_WAYS-1:0] w_set_valid;
    logic [WAY_W-1:0]    w_set_mru;
    logic                w_has_inv;
    logic [WAY_W-1:0]    w_inv_way;
    logic [WAY_W-1:0]    w_nmru;
    logic [WAY_W-1:0]    w_sel_way;

    assign w_set_valid = r_valid[i_victim_set];
    assign w_set_mru   = r_mru[i_victim_set];

    // Lowest-indexed invalid way: scan high to low so the lowest match wins.
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!w_set_valid[w]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
    end

    // NMRU candidate: with two ways the other way; otherwise MRU plus a
    // never-zero LFSR offset, wrapping naturally in WAY_W bits.
    generate
        if (NUM_WAYS > 2) begin : g_lfsr
            logic [WAY_W-1:0] w_offset;
            victim_select_lfsr #(.NUM_BITS(WAY_W)) u_lfsr (
                .clock     (clock),
                .reset     (reset),
                .i_advance (w_accept & ~w_has_inv),
                .o_state   (w_offset)
            );
            assign w_nmru = WAY_W'(w_set_mru + w_offset);
        end else begin : g_two_way
            assign w_nmru = ~w_set_mru;
        end
    endgenerate

    assign w_sel_way = w_has_inv ? w_inv_way : w_nmru;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: accept a request in IDLE, hold the result until ack.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_victim_req) begin
                    w_state_nxt = ST_RESP;
                    w_accept    = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_victim_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the selection from pre-edge state; held untouched while pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_way   <= '0;
            r_evict <= 1'b0;
        end else if (w_accept) begin
            r_way   <= w_sel_way;
            r_evict <= ~w_has_inv;
        end
    end

    // Valid/MRU tracking; later assignments win, so fill beats inval on the
    // valid bit and beats access on the MRU pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_mru   <= '0;
        end else begin
            if (i_access_valid) r_mru[i_access_set] <= i_access_way;
            if (i_inval_valid)  r_valid[i_inval_set][i_inval_way] <= 1'b0;
            if (i_fill_valid) begin
                r_valid[i_fill_set][i_fill_way] <= 1'b1;
                r_mru[i_fill_set]               <= i_fill_way;
            end
        end
    end

    assign o_victim_busy  = (r_state != ST_IDLE);
    assign o_victim_valid = (r_state == ST_RESP);
    assign o_victim_way   = r_way;
    assign o_victim_evict = r_evict;

endmodule
